// File: rtl/test_vector_recorder.sv
// ============================================================================
// Module   : test_vector_recorder
// Purpose  : Records live 4-bit adder stimulus/response tuples into on-chip
//            vector memory in the 14-bit xxxx_yyyy_i_o_ssss format. On stop,
//            streams the stored vectors out over valid/ready and flags the
//            final word.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module test_vector_recorder #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 1000,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cap_valid,
    input  logic [3:0]       cap_x,
    input  logic [3:0]       cap_y,
    input  logic             cap_ci,
    input  logic             cap_co,
    input  logic [3:0]       cap_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             recording,
    output logic             full,
    output logic [AW-1:0]    count,
    output logic             overflow,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_DUMP   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [AW-1:0] C_DEPTH = AW'(DEPTH);
    localparam logic [AW-1:0] C_ONE   = AW'(1);

    state_t            state_q, state_d;
    logic [AW-1:0]     count_q, count_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              dump_go_q, dump_go_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [WIDTH-1:0]  out_data_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              w_full;
    logic              w_capture;
    logic              w_load;
    logic              w_xfer;
    logic [AW-1:0]     w_last_idx;
    logic [WIDTH-1:0]  w_cap_word;

    assign w_full     = (count_q == C_DEPTH);
    assign w_cap_word = {cap_x, cap_y, cap_ci, cap_co, cap_s};
    assign w_last_idx = count_q - C_ONE;
    assign w_xfer     = out_valid_q & out_ready;

    // A capture only lands in RECORD with room left; a start in the same
    // cycle restarts the recording and drops the tuple.
    assign w_capture  = (state_q == S_RECORD) & cap_valid & ~w_full & ~start;

    // The output register reloads whenever it is empty or being drained.
    // dump_go_q delays the first read by one cycle so the first word appears
    // two edges after the edge that sampled stop.
    assign w_load     = (state_q == S_DUMP) & dump_go_q &
                        (~out_valid_q | out_ready) & (rd_ptr_q != count_q);

    // Vector memory write port (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (w_capture) begin
            mem_q[count_q] <= w_cap_word;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            dump_go_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            dump_go_q   <= dump_go_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (w_load) begin
                out_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        done_d      = done_q;
        dump_go_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_RECORD;
                    count_d    = '0;
                    rd_ptr_d   = '0;
                    overflow_d = 1'b0;
                    done_d     = 1'b0;
                end
            end

            S_RECORD: begin
                if (start) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else begin
                    if (cap_valid) begin
                        if (w_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + C_ONE;
                        end
                    end
                    if (stop) begin
                        rd_ptr_d = '0;
                        // The post-capture count is non-zero if anything was
                        // stored before or is being stored this cycle.
                        if ((count_q != '0) || w_capture) begin
                            state_d = S_DUMP;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            S_DUMP: begin
                dump_go_d = 1'b1;
                if (w_load) begin
                    rd_ptr_d    = rd_ptr_q + C_ONE;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_ptr_q == w_last_idx);
                end else if (w_xfer) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                if (w_xfer && out_last_q) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    dump_go_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign recording = (state_q == S_RECORD);
    assign full      = w_full;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_test_vector_recorder.sv
// ============================================================================
// Module   : tb_test_vector_recorder
// Purpose  : Scoreboard bench for test_vector_recorder. One full-depth
//            instance for the functional sequences and one DEPTH=4 instance
//            for the saturation/overflow case.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_test_vector_recorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Full-depth instance
    logic        a_start, a_stop, a_cap_valid, a_ci, a_co, a_ready;
    logic [3:0]  a_x, a_y, a_s;
    logic        a_valid, a_last, a_rec, a_full, a_ov, a_done;
    logic [13:0] a_data;
    logic [9:0]  a_count;

    // Small instance for saturation
    logic        b_start, b_stop, b_cap_valid, b_ci, b_co, b_ready;
    logic [3:0]  b_x, b_y, b_s;
    logic        b_valid, b_last, b_rec, b_full, b_ov, b_done;
    logic [13:0] b_data;
    logic [2:0]  b_count;

    test_vector_recorder #(.WIDTH(14), .DEPTH(1000), .AW(10)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop),
        .cap_valid(a_cap_valid), .cap_x(a_x), .cap_y(a_y), .cap_ci(a_ci),
        .cap_co(a_co), .cap_s(a_s), .out_valid(a_valid), .out_ready(a_ready),
        .out_data(a_data), .out_last(a_last), .recording(a_rec),
        .full(a_full), .count(a_count), .overflow(a_ov), .done(a_done)
    );

    test_vector_recorder #(.WIDTH(14), .DEPTH(4), .AW(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop),
        .cap_valid(b_cap_valid), .cap_x(b_x), .cap_y(b_y), .cap_ci(b_ci),
        .cap_co(b_co), .cap_s(b_s), .out_valid(b_valid), .out_ready(b_ready),
        .out_data(b_data), .out_last(b_last), .recording(b_rec),
        .full(b_full), .count(b_count), .overflow(b_ov), .done(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int a_xfers  = 0;
    int b_xfers  = 0;

    // Expected words: bit 14 = last flag, bits 13:0 = vector
    logic [14:0] qa[$];
    logic [14:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each presented word with the head of the queue; pop on transfer
    always @(negedge clk) begin
        if (!reset && a_valid) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_word: got 0x%0h, expected no word", a_data);
            end else begin
                chk("a_data", {18'd0, a_data}, {18'd0, qa[0][13:0]});
                chk("a_last", {31'd0, a_last}, {31'd0, qa[0][14]});
                if (a_ready) begin
                    void'(qa.pop_front());
                    a_xfers++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_valid) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_word: got 0x%0h, expected no word", b_data);
            end else begin
                chk("b_data", {18'd0, b_data}, {18'd0, qb[0][13:0]});
                chk("b_last", {31'd0, b_last}, {31'd0, qb[0][14]});
                if (b_ready) begin
                    void'(qb.pop_front());
                    b_xfers++;
                end
            end
        end
    end

    task automatic a_pulse_start();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_cap(input logic [3:0] x, input logic [3:0] y,
                         input logic ci, input logic co, input logic [3:0] s);
        a_cap_valid = 1'b1;
        a_x = x; a_y = y; a_ci = ci; a_co = co; a_s = s;
        tick();
        a_cap_valid = 1'b0;
    endtask

    // Stop, then confirm out_valid rises exactly on the second edge after
    task automatic a_stop_latency(input string tag);
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        chk({tag, "_valid_e0"}, {31'd0, a_valid}, 32'd0);
        tick();
        chk({tag, "_valid_e1"}, {31'd0, a_valid}, 32'd0);
        tick();
        chk({tag, "_valid_e2"}, {31'd0, a_valid}, 32'd1);
    endtask

    task automatic a_wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!a_done && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_timeout"}, {31'd0, a_done}, 32'd1);
    endtask

    task automatic push_a_default3();
        qa.push_back({1'b0, 14'b00110100000111});
        qa.push_back({1'b0, 14'b11110001110001});
        qa.push_back({1'b1, 14'b00000000000000});
    endtask

    task automatic cap_a_default3();
        a_cap(4'd3, 4'd4, 1'b0, 1'b0, 4'd7);
        a_cap(4'd15, 4'd1, 1'b1, 1'b1, 4'd1);
        a_cap(4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin : watchdog
        #300000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : stim
        bit         pat [6];
        logic [3:0] xv;
        int         n;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        a_start = 0; a_stop = 0; a_cap_valid = 0; a_ready = 0;
        a_x = 0; a_y = 0; a_ci = 0; a_co = 0; a_s = 0;
        b_start = 0; b_stop = 0; b_cap_valid = 0; b_ready = 0;
        b_x = 0; b_y = 0; b_ci = 0; b_co = 0; b_s = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_count",    {22'd0, a_count}, 32'd0);
        chk("rst_valid",    {31'd0, a_valid}, 32'd0);
        chk("rst_done",     {31'd0, a_done},  32'd0);
        chk("rst_rec",      {31'd0, a_rec},   32'd0);
        chk("rst_full",     {31'd0, a_full},  32'd0);
        chk("rst_overflow", {31'd0, a_ov},    32'd0);
        chk("rst_last",     {31'd0, a_last},  32'd0);
        chk("rst_data",     {18'd0, a_data},  32'd0);

        // 1: three vectors, ready held high, no bubbles
        a_ready = 1'b1;
        a_pulse_start();
        chk("t1_recording", {31'd0, a_rec}, 32'd1);
        push_a_default3();
        cap_a_default3();
        chk("t1_count_rec", {22'd0, a_count}, 32'd3);
        a_stop_latency("t1");
        repeat (3) tick();
        chk("t1_done",      {31'd0, a_done},  32'd1);
        chk("t1_valid_off", {31'd0, a_valid}, 32'd0);
        chk("t1_count",     {22'd0, a_count}, 32'd3);
        chk("t1_q_empty",   qa.size(),        32'd0);
        chk("t1_xfers",     a_xfers,          32'd3);

        // 2: same dump with ready toggling 1,0,0,1,0,1
        a_ready = 1'b0;
        a_pulse_start();
        chk("t2_done_clr", {31'd0, a_done}, 32'd0);
        push_a_default3();
        cap_a_default3();
        a_stop_latency("t2");
        for (int i = 0; i < 6; i++) begin
            a_ready = pat[i];
            tick();
        end
        a_ready = 1'b0;
        chk("t2_done",    {31'd0, a_done}, 32'd1);
        chk("t2_q_empty", qa.size(),       32'd0);
        chk("t2_xfers",   a_xfers,         32'd6);

        // 3: start then stop with nothing captured
        a_ready = 1'b1;
        a_pulse_start();
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        chk("t3_done",  {31'd0, a_done},  32'd1);
        chk("t3_count", {22'd0, a_count}, 32'd0);
        chk("t3_rec",   {31'd0, a_rec},   32'd0);
        repeat (4) tick();
        chk("t3_valid", {31'd0, a_valid}, 32'd0);
        chk("t3_xfers", a_xfers,          32'd6);

        // 4: stop coincident with the second capture
        a_pulse_start();
        qa.push_back({1'b0, 14'b00010010000011});
        qa.push_back({1'b1, 14'b10011001110011});
        a_cap(4'd1, 4'd2, 1'b0, 1'b0, 4'd3);
        a_cap_valid = 1'b1;
        a_x = 4'd9; a_y = 4'd9; a_ci = 1'b1; a_co = 1'b1; a_s = 4'd3;
        a_stop = 1'b1;
        tick();
        a_cap_valid = 1'b0;
        a_stop = 1'b0;
        chk("t4_count", {22'd0, a_count}, 32'd2);
        a_wait_done("t4", 20);
        chk("t4_q_empty", qa.size(), 32'd0);
        chk("t4_xfers",   a_xfers,   32'd8);

        // 5: reset between edges mid-dump, then a one-vector dump
        a_pulse_start();
        push_a_default3();
        cap_a_default3();
        a_stop_latency("t5");
        #1;
        reset = 1'b1;
        #1;
        chk("t5_valid_rst", {31'd0, a_valid}, 32'd0);
        chk("t5_done_rst",  {31'd0, a_done},  32'd0);
        chk("t5_count_rst", {22'd0, a_count}, 32'd0);
        qa.delete();
        tick();
        reset = 1'b0;
        tick();
        a_pulse_start();
        qa.push_back({1'b1, 14'b01011010011111});
        a_cap(4'd5, 4'd10, 1'b0, 1'b1, 4'd15);
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        a_wait_done("t5", 20);
        chk("t5_count",   {22'd0, a_count}, 32'd1);
        chk("t5_q_empty", qa.size(),        32'd0);
        chk("t5_xfers",   a_xfers,          32'd9);

        // 6: DEPTH=4 instance, six captures x=1..6
        b_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            xv = 4'(k);
            if (k <= 4) begin
                qb.push_back({(k == 4), xv, 4'd0, 1'b0, 1'b0, xv});
            end
            b_cap_valid = 1'b1;
            b_x = xv; b_y = 4'd0; b_ci = 1'b0; b_co = 1'b0; b_s = xv;
            tick();
            b_cap_valid = 1'b0;
            if (k == 4) begin
                chk("t6_count4", {29'd0, b_count}, 32'd4);
                chk("t6_full4",  {31'd0, b_full},  32'd1);
                chk("t6_ov4",    {31'd0, b_ov},    32'd0);
            end
        end
        chk("t6_count",    {29'd0, b_count}, 32'd4);
        chk("t6_full",     {31'd0, b_full},  32'd1);
        chk("t6_overflow", {31'd0, b_ov},    32'd1);
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        n = 0;
        while (!b_done && n < 20) begin
            tick();
            n++;
        end
        chk("t6_done_timeout", {31'd0, b_done}, 32'd1);
        chk("t6_q_empty", qb.size(),        32'd0);
        chk("t6_xfers",   b_xfers,          32'd4);
        chk("t6_count_d", {29'd0, b_count}, 32'd4);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/test_vector_recorder.md
Name: test_vector_recorder

Overview:
- Writer-side counterpart to the team's file-driven self-checking benches.
- Captures live stimulus/response tuples of a 4-bit adder interface into on-chip vector memory, packed in the team's 14-bit vector format (xxxx_yyyy_i_o_ssss).
- On command, streams the captured vectors out over a valid/ready interface, marking the final word, so they can be dumped into a vector file.
- Sits beside the adder DUT in the reference-capture harness.

Parameters:
- WIDTH, 14, packed vector width; fixed at 4+4+1+1+4.
- DEPTH, 1000, vector memory entries; matches the bench vector array depth.
- AW, 10, address/count width; must satisfy 2^AW > DEPTH.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse; begins a new recording
- stop  in  1  single-cycle pulse; ends recording and begins dump
- cap_valid  in  1  capture strobe; tuple below is valid this cycle
- cap_x  in  4  adder operand x
- cap_y  in  4  adder operand y
- cap_ci  in  1  adder carry-in
- cap_co  in  1  adder carry-out
- cap_s  in  4  adder sum
- out_valid  out  1  out_data holds a vector word
- out_ready  in  1  sink accepts the word
- out_data  out  WIDTH  packed vector {x,y,ci,co,s}, MSB first
- out_last  out  1  high with the final word of a dump
- recording  out  1  high in RECORD state
- full  out  1  count == DEPTH
- count  out  AW  number of stored vectors
- overflow  out  1  sticky; a capture was dropped because memory was full
- done  out  1  dump complete

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, count=0, read pointer=0. All outputs 0 (out_valid, out_last, out_data, recording, full, overflow, done). Memory contents are don't-care and are not cleared.
- FSM states: IDLE, RECORD, DUMP, DONE.
- IDLE:
  - start -> RECORD; count<=0, overflow<=0, done<=0.
  - stop and cap_valid are ignored.
- RECORD (recording=1):
  - Each cycle with cap_valid=1 and full=0: mem[count] <= {cap_x,cap_y,cap_ci,cap_co,cap_s}, then count <= count+1.
  - cap_valid=1 with full=1: word dropped, overflow <= 1, count unchanged.
  - start in RECORD: restart; count<=0, overflow<=0. A cap_valid in the same cycle is dropped.
  - stop in RECORD: a cap_valid in the same cycle is captured first. Next state is DUMP if the post-capture count > 0, otherwise DONE.
  - start and stop in the same cycle: start wins.
- DUMP:
  - Read pointer starts at 0. Memory read is synchronous.
  - out_valid rises exactly 2 rising edges after the edge that sampled stop.
  - A transfer occurs on each rising edge with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - With out_ready held high, throughput is 1 word/cycle with no bubbles.
  - out_last=1 exactly when the word presented is mem[count-1].
  - The transfer of the last word -> DONE; out_valid=0 the following cycle.
  - start and stop are ignored in DUMP.
  - count stays constant through DUMP and DONE.
- DONE:
  - done=1 held until next start or reset.
  - start -> RECORD, same clearing as from IDLE.
- full is combinational from count (count==DEPTH) and is valid in all states.
- Packing example: x=3, y=4, ci=0, s=7, co=0 -> 14'b0011_0100_0_0_0111.
- No arithmetic is checked inside the block; it records what it sees. count saturates at DEPTH and never wraps.

Test Plan:
- Reset; start; capture (3,4,0,co=0,s=7), (15,1,1,co=1,s=1), (0,0,0,0,0); stop; out_ready=1 -> out_valid 2 edges after stop, then words 00110100000111, 11110001110001, 00000000000000 on consecutive cycles; out_last only on the 3rd; done=1 after; count=3.
- Same 3-vector dump with out_ready toggling 1,0,0,1,0,1 -> each word held stable while stalled; exactly 3 transfers, in order; no duplicates or drops.
- DEPTH=4 build: 6 captures of increasing x=1..6 -> count=4, full=1, overflow=1; dump yields x=1..4 only, out_last on the x=4 word.
- start then stop with no captures -> DONE the next cycle; out_valid never asserts; done=1; count=0.
- stop asserted in the same cycle as cap_valid (x=9,y=9,ci=1,co=1,s=3) as the 2nd capture -> count=2; that word is dumped last with out_last=1.
- Reset asserted mid-DUMP between clock edges -> out_valid, done and count go 0 immediately; a subsequent start/capture/stop of 1 vector dumps only that vector.
